// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter with registered one-hot grant, hold and fixed-priority fallback.
// A winner keeps the resource for max(weight,1) consecutive cycles unless it drops its request.
module weighted_rr_arbiter #(
    parameter int unsigned NUM_CLIENTS = 8,
    parameter int unsigned WEIGHT_W    = 4,
    parameter bit          CAN_HOLD    = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CLIENTS-1:0]           requests,
    input  logic [NUM_CLIENTS*WEIGHT_W-1:0]  weights,
    input  logic                             prio_mode,
    input  logic                             hold,
    output logic [NUM_CLIENTS-1:0]           grants,
    output logic                             grant_valid,
    output logic [$clog2(NUM_CLIENTS)-1:0]   grant_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_CLIENTS);

    logic [IDX_W-1:0]       last_owner;
    logic [WEIGHT_W-1:0]    credit;

    logic                   hold_eff;
    logic                   owner_req;
    logic                   any_req;
    logic                   rr_found;
    logic [IDX_W-1:0]       rr_idx;
    logic [IDX_W-1:0]       fp_idx;
    logic [IDX_W-1:0]       cand;
    logic [IDX_W-1:0]       win_idx;
    logic [WEIGHT_W-1:0]    win_weight;
    logic [WEIGHT_W-1:0]    w_eff;

    logic [NUM_CLIENTS-1:0] grants_d;
    logic                   valid_d;
    logic [IDX_W-1:0]       idx_d;
    logic [IDX_W-1:0]       last_d;
    logic [WEIGHT_W-1:0]    credit_d;

    assign hold_eff  = CAN_HOLD && hold;
    assign owner_req = grant_valid && requests[grant_idx];
    assign any_req   = |requests;

    // Rotating search starting just past the last winner; the current owner comes last.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            cand = IDX_W'((32'(last_owner) + i + 32'd1) % NUM_CLIENTS);
            if (!rr_found && requests[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        fp_idx = '0;
        for (int i = int'(NUM_CLIENTS) - 1; i >= 0; i--) begin
            if (requests[i]) begin
                fp_idx = IDX_W'(i);
            end
        end
    end

    assign win_idx    = prio_mode ? fp_idx : rr_idx;
    assign win_weight = weights[32'(win_idx)*WEIGHT_W +: WEIGHT_W];
    assign w_eff      = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;

    // Next-state decision: hold, then burst continuation, then fresh arbitration.
    always_comb begin
        valid_d  = grant_valid;
        idx_d    = grant_idx;
        last_d   = last_owner;
        credit_d = credit;
        if (owner_req && (hold_eff || credit != '0)) begin
            if (!hold_eff) begin
                credit_d = credit - WEIGHT_W'(1);
            end
        end else if (any_req) begin
            valid_d  = 1'b1;
            idx_d    = win_idx;
            last_d   = win_idx;
            credit_d = w_eff - WEIGHT_W'(1);
        end else begin
            valid_d  = 1'b0;
            idx_d    = '0;
            credit_d = '0;
        end
        grants_d = valid_d ? (NUM_CLIENTS'(1) << idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grants      <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            credit      <= '0;
            last_owner  <= IDX_W'(NUM_CLIENTS - 1);
        end else begin
            grants      <= grants_d;
            grant_valid <= valid_d;
            grant_idx   <= idx_d;
            credit      <= credit_d;
            last_owner  <= last_d;
        end
    end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Scoreboard bench for weighted_rr_arbiter: stimulus queues the expected grant of each edge,
// a negedge monitor pops and compares grants, grant_valid and grant_idx.
module tb_weighted_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  requests;
    logic [31:0] weights;
    logic        prio_mode;
    logic        hold;
    logic [7:0]  grants;
    logic        grant_valid;
    logic [2:0]  grant_idx;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    weighted_rr_arbiter #(
        .NUM_CLIENTS(8),
        .WEIGHT_W   (4),
        .CAN_HOLD   (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .requests   (requests),
        .weights    (weights),
        .prio_mode  (prio_mode),
        .hold       (hold),
        .grants     (grants),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] onehot_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Monitor: each popped entry is the grant the DUT must show after the matching edge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (grants !== e) begin
                errors++;
                $display("FAIL grants t=%0t got %02h want %02h", $time, grants, e);
            end
            checks++;
            if (grant_valid !== (|e)) begin
                errors++;
                $display("FAIL grant_valid t=%0t got %0b want %0b", $time, grant_valid, |e);
            end
            checks++;
            if (grant_idx !== onehot_idx(e)) begin
                errors++;
                $display("FAIL grant_idx t=%0t got %0d want %0d", $time, grant_idx, onehot_idx(e));
            end
        end
    end

    task automatic step(input logic r, input logic [7:0] req, input logic h,
                        input logic m, input logic [7:0] e);
        rst_n     = r;
        requests  = req;
        hold      = h;
        prio_mode = m;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic set_w(input int c, input int v);
        weights[c*4 +: 4] = 4'(v);
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] seq1 [9];
        rst_n     = 1'b0;
        requests  = 8'h00;
        prio_mode = 1'b0;
        hold      = 1'b0;
        weights   = {8{4'h1}};

        // Plain rotation with unit weights.
        do_reset();
        do_reset();
        seq1 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        for (int i = 0; i < 9; i++) step(1'b1, 8'hFF, 1'b0, 1'b0, seq1[i]);

        // Weights 3 and 2 between clients 0 and 1.
        do_reset();
        set_w(0, 3);
        set_w(1, 2);
        for (int k = 0; k < 2; k++) begin
            repeat (3) step(1'b1, 8'h03, 1'b0, 1'b0, 8'h01);
            repeat (2) step(1'b1, 8'h03, 1'b0, 1'b0, 8'h02);
        end

        // Weight 0 on client 1 behaves as weight 1.
        do_reset();
        set_w(1, 0);
        for (int k = 0; k < 2; k++) begin
            repeat (3) step(1'b1, 8'h03, 1'b0, 1'b0, 8'h01);
            step(1'b1, 8'h03, 1'b0, 1'b0, 8'h02);
        end

        // Sole requester re-grants back to back, then goes idle.
        do_reset();
        weights = {8{4'h1}};
        set_w(2, 2);
        repeat (5) step(1'b1, 8'h04, 1'b0, 1'b0, 8'h04);
        step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00);

        // Hold freezes client 4's remaining credit.
        do_reset();
        weights = {8{4'h1}};
        set_w(4, 4);
        step(1'b1, 8'h10, 1'b0, 1'b0, 8'h10);
        repeat (5) step(1'b1, 8'hFF, 1'b1, 1'b0, 8'h10);
        repeat (3) step(1'b1, 8'hFF, 1'b0, 1'b0, 8'h10);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 8'h20);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 8'h40);

        // Hold with no owner requesting is ignored.
        step(1'b1, 8'h01, 1'b1, 1'b0, 8'h01);

        // Fixed priority, then back to rotation from last_owner+1.
        do_reset();
        weights = {8{4'h1}};
        set_w(2, 2);
        step(1'b1, 8'h0C, 1'b0, 1'b1, 8'h04);
        step(1'b1, 8'h0C, 1'b0, 1'b1, 8'h04);
        step(1'b1, 8'h0D, 1'b0, 1'b1, 8'h01);
        step(1'b1, 8'h0D, 1'b0, 1'b0, 8'h04);
        step(1'b1, 8'h0D, 1'b0, 1'b0, 8'h04);
        step(1'b1, 8'h0D, 1'b0, 1'b0, 8'h08);
        step(1'b1, 8'h0D, 1'b0, 1'b0, 8'h01);

        // Owner drops its request mid-burst, then a mid-burst reset.
        do_reset();
        weights = {8{4'h1}};
        set_w(1, 4);
        set_w(3, 4);
        step(1'b1, 8'h0A, 1'b0, 1'b0, 8'h02);
        step(1'b1, 8'h0A, 1'b0, 1'b0, 8'h02);
        step(1'b1, 8'h08, 1'b0, 1'b0, 8'h08);
        step(1'b1, 8'h08, 1'b0, 1'b0, 8'h08);
        step(1'b0, 8'h08, 1'b0, 1'b0, 8'h00);
        step(1'b1, 8'h08, 1'b0, 1'b0, 8'h08);

        // Drain the scoreboard with a bounded wait.
        begin
            int budget;
            budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(negedge clk);
                #1;
                budget--;
            end
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain pending %0d want 0", exp_q.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
